wb_mux_n: RTL



---
 rtl/wb_mux_pkg.sv | 22 ++
 rtl/wb_addr_decode.sv | 30 +++
 rtl/wb_mux_n.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone 1:N address-decoding mux.
package wb_mux_pkg;

    localparam int MAX_SLAVES = 8;
    localparam int IDX_W      = $clog2(MAX_SLAVES);
    localparam int TMO_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mux_state_t;

    // Request fields captured from the master when a transfer is accepted.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

endpackage

// File: rtl/wb_addr_decode.sv
// Purpose: combinational base/window address decode, lowest slave index wins.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the result is consumed only when the mux is idle.
module wb_addr_decode
    import wb_mux_pkg::*;
#(
    parameter int                          NUM_SLAVES  = 4,
    parameter logic [32*NUM_SLAVES-1:0]    BASE_ADDRS  = {32'h3000_3000, 32'h3000_2000,
                                                          32'h3000_1000, 32'h3000_0000},
    parameter logic [8*NUM_SLAVES-1:0]     ADDR_WIDTHS = {8'd12, 8'd12, 8'd12, 8'd12}
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [IDX_W-1:0] index
);

    // Walk from the top index down so the lowest matching slave is the last writer.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr >> ADDR_WIDTHS[8*i +: 8]) ==
                (BASE_ADDRS[32*i +: 32] >> ADDR_WIDTHS[8*i +: 8])) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mux_n.sv
// Purpose: Wishbone classic 1-master to N-slave mux with decode-miss and timeout errors.
// Latency: slave strobed from cycle 1; master ack/err one cycle after slave ack, miss err at cycle 1.
// Backpressure: one transfer outstanding; new requests are only accepted in IDLE.
module wb_mux_n
    import wb_mux_pkg::*;
#(
    parameter int                          NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]    BASE_ADDRS     = {32'h3000_3000, 32'h3000_2000,
                                                             32'h3000_1000, 32'h3000_0000},
    parameter logic [8*NUM_SLAVES-1:0]     ADDR_WIDTHS    = {8'd12, 8'd12, 8'd12, 8'd12},
    parameter int                          TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         wbm_cyc_i,
    input  logic                         wbm_stb_i,
    input  logic                         wbm_we_i,
    input  logic [3:0]                   wbm_sel_i,
    input  logic [31:0]                  wbm_adr_i,
    input  logic [31:0]                  wbm_dat_i,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    output logic [31:0]                  wbm_dat_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    output logic [NUM_SLAVES-1:0]        wbs_we_o,
    output logic [4*NUM_SLAVES-1:0]      wbs_sel_o,
    output logic [32*NUM_SLAVES-1:0]     wbs_adr_o,
    output logic [32*NUM_SLAVES-1:0]     wbs_dat_o,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    input  logic [32*NUM_SLAVES-1:0]     wbs_dat_i
);

    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

    mux_state_t           state_q, state_nxt;
    wb_req_t              req_q, req_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [TMO_CNT_W-1:0] cnt_q, cnt_nxt;
    logic                 ack_q, ack_nxt;
    logic                 err_q, err_nxt;
    logic [31:0]          rdat_q, rdat_nxt;

    logic                 dec_hit;
    logic [IDX_W-1:0]     dec_idx;
    logic                 sel_ack;
    logic [31:0]          sel_dat;

    wb_addr_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .BASE_ADDRS  (BASE_ADDRS),
        .ADDR_WIDTHS (ADDR_WIDTHS)
    ) u_decode (
        .adr   (wbm_adr_i),
        .hit   (dec_hit),
        .index (dec_idx)
    );

    // Only the latched slave's termination is visible; all others are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack = wbs_ack_i[i];
                sel_dat = wbs_dat_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        req_nxt   = req_q;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt_q;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        rdat_nxt  = rdat_q;
        case (state_q)
            ST_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (dec_hit) begin
                        state_nxt = ST_BUSY;
                        idx_nxt   = dec_idx;
                        req_nxt   = '{adr: wbm_adr_i, dat: wbm_dat_i,
                                      sel: wbm_sel_i, we: wbm_we_i};
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_RESP;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // Master abort takes priority over a same-cycle slave ack.
                if (!wbm_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (sel_ack) begin
                    state_nxt = ST_RESP;
                    ack_nxt   = 1'b1;
                    rdat_nxt  = sel_dat;
                end else if (cnt_q + 1'b1 == TMO_LIMIT) begin
                    state_nxt = ST_RESP;
                    err_nxt   = 1'b1;
                    rdat_nxt  = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_nxt;
            req_q   <= req_nxt;
            idx_q   <= idx_nxt;
            cnt_q   <= cnt_nxt;
            ack_q   <= ack_nxt;
            err_q   <= err_nxt;
            rdat_q  <= rdat_nxt;
        end
    end

    assign wbm_ack_o = ack_q;
    assign wbm_err_o = err_q;
    assign wbm_dat_o = rdat_q;

    // Slave side is driven from registered state, so reset clears it immediately.
    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        wbs_we_o  = '0;
        wbs_sel_o = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (state_q == ST_BUSY && idx_q == IDX_W'(i)) begin
                wbs_cyc_o[i]          = 1'b1;
                wbs_stb_o[i]          = 1'b1;
                wbs_we_o[i]           = req_q.we;
                wbs_sel_o[4*i +: 4]   = req_q.sel;
                wbs_adr_o[32*i +: 32] = req_q.adr;
                wbs_dat_o[32*i +: 32] = req_q.dat;
            end
        end
    end

endmodule
